// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the buart holding register and the CPU bus.
// Captures bytes with a two-state ack handshake and exposes data/status registers plus a level irq.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int THRESHOLD  = 1
) (
    input  logic        input_clk,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic [7:0]  uart_data,
    output logic        uart_rd,
    input  logic        sys_rd,
    input  logic [3:0]  sys_we,
    input  logic        sys_data_sel,
    input  logic        sys_stat_sel,
    input  logic [31:0] sys_wdata,
    output logic [31:0] sys_rdata,
    output logic        irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_ACK  = 1'b1;

    localparam logic [DEPTH_LOG2:0]   COUNT_FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE    = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE      = 1;
    localparam logic [DEPTH_LOG2:0]   THRESH_COUNT = THRESHOLD[DEPTH_LOG2:0];

    logic [7:0]            mem [DEPTH];
    logic [0:0]            state;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  overrun;
    logic                  overrun_next;
    logic                  irq_en;
    logic                  irq_en_next;
    logic [31:0]           stat_word;

    logic data_rd;
    logic stat_rd;
    logic ctrl_we;
    logic flush;
    logic clear_overrun;
    logic empty;
    logic full;
    logic ingest;
    logic pop;
    logic push;
    logic drop;
    logic unused_inputs;

    assign data_rd       = sys_rd & sys_data_sel;
    assign stat_rd       = sys_rd & sys_stat_sel;
    assign ctrl_we       = sys_stat_sel & sys_we[0];
    assign flush         = ctrl_we & sys_wdata[1];
    assign clear_overrun = ctrl_we & sys_wdata[0];
    assign empty         = (count == '0);
    assign full          = (count == COUNT_FULL);
    assign ingest        = (state == STATE_IDLE) & uart_valid;
    assign pop           = data_rd & ~empty;

    // A pop in the same cycle frees a slot for the incoming byte; a flush swallows it silently.
    assign push = ingest & (~full | pop) & ~flush;
    assign drop = ingest & full & ~pop & ~flush;

    assign unused_inputs = ^{sys_we[3:1], sys_wdata[31:3]};

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push & ~pop) begin
            count_next = count + COUNT_ONE;
        end else if (pop & ~push) begin
            count_next = count - COUNT_ONE;
        end
    end

    // A new overrun event outranks a software clear in the same cycle.
    always_comb begin
        overrun_next = overrun;
        if (clear_overrun) begin
            overrun_next = 1'b0;
        end
        if (drop) begin
            overrun_next = 1'b1;
        end
    end

    always_comb begin
        irq_en_next = irq_en;
        if (ctrl_we) begin
            irq_en_next = sys_wdata[2];
        end
    end

    always_comb begin
        stat_word = '0;
        stat_word[16 +: DEPTH_LOG2 + 1] = count;
        stat_word[3:0] = {irq_en, overrun, full, ~empty};
    end

    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            state   <= STATE_IDLE;
            uart_rd <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (uart_valid) begin
                        state   <= STATE_ACK;
                        uart_rd <= 1'b1;
                    end else begin
                        uart_rd <= 1'b0;
                    end
                end
                default: begin
                    state   <= STATE_IDLE;
                    uart_rd <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge input_clk) begin
        if (push) begin
            mem[wr_ptr] <= uart_data;
        end
    end

    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            count   <= count_next;
            overrun <= overrun_next;
            irq_en  <= irq_en_next;
            irq     <= irq_en & ((count_next >= THRESH_COUNT) | overrun_next);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
            end
        end
    end

    // Bit 8 flags a valid byte so software can poll the data register alone.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            sys_rdata <= '0;
        end else if (data_rd) begin
            if (pop) begin
                sys_rdata <= {23'b0, 1'b1, mem[rd_ptr]};
            end else begin
                sys_rdata <= '0;
            end
        end else if (stat_rd) begin
            sys_rdata <= stat_word;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed register values.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int THRESH = 4;

    logic        input_clk;
    logic        reset;
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        uart_rd;
    logic        sys_rd;
    logic [3:0]  sys_we;
    logic        sys_data_sel;
    logic        sys_stat_sel;
    logic [31:0] sys_wdata;
    logic [31:0] sys_rdata;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;
    int rd_pulses    = 0;

    logic [7:0]  m_q[$];
    logic        m_ovr     = 1'b0;
    logic        m_irq_en  = 1'b0;
    logic        m_busy    = 1'b0;
    logic        m_uart_rd = 1'b0;
    logic        m_irq     = 1'b0;
    logic [31:0] m_rdata   = '0;

    uart_rx_fifo #(.DEPTH_LOG2(4), .THRESHOLD(THRESH)) dut (
        .input_clk    (input_clk),
        .reset        (reset),
        .uart_valid   (uart_valid),
        .uart_data    (uart_data),
        .uart_rd      (uart_rd),
        .sys_rd       (sys_rd),
        .sys_we       (sys_we),
        .sys_data_sel (sys_data_sel),
        .sys_stat_sel (sys_stat_sel),
        .sys_wdata    (sys_wdata),
        .sys_rdata    (sys_rdata),
        .irq          (irq)
    );

    initial begin
        input_clk = 1'b0;
        forever #5 input_clk = ~input_clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the receiver takes a byte whenever it did not acknowledge in the previous cycle.
    task automatic model_step();
        bit          ingest;
        bit          data_rd;
        bit          stat_rd;
        bit          ctrl;
        bit          flush;
        bit          ovr_set;
        bit          old_irq_en;
        int          n;
        logic [31:0] st;
        ingest  = !m_busy && uart_valid;
        data_rd = sys_rd && sys_data_sel;
        stat_rd = sys_rd && sys_stat_sel;
        ctrl    = sys_stat_sel && sys_we[0];
        flush   = ctrl && sys_wdata[1];
        ovr_set = 1'b0;
        n       = m_q.size();
        if (data_rd) begin
            m_rdata = (n > 0) ? (32'h100 | 32'(m_q[0])) : 32'h0;
        end else if (stat_rd) begin
            st = '0;
            st[20:16] = 5'(n);
            st[3] = m_irq_en;
            st[2] = m_ovr;
            st[1] = (n == DEPTH);
            st[0] = (n != 0);
            m_rdata = st;
        end
        if (data_rd && n > 0) void'(m_q.pop_front());
        if (ingest && !flush) begin
            if (m_q.size() < DEPTH) m_q.push_back(uart_data);
            else ovr_set = 1'b1;
        end
        if (flush) m_q.delete();
        if (ctrl && sys_wdata[0]) m_ovr = 1'b0;
        if (ovr_set) m_ovr = 1'b1;
        old_irq_en = m_irq_en;
        if (ctrl) m_irq_en = sys_wdata[2];
        m_irq     = old_irq_en && ((m_q.size() >= THRESH) || m_ovr);
        m_uart_rd = ingest;
        m_busy    = ingest;
    endtask

    initial begin
        forever begin
            @(posedge input_clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_ovr = 1'b0; m_irq_en = 1'b0; m_busy = 1'b0;
                m_uart_rd = 1'b0; m_irq = 1'b0; m_rdata = '0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge input_clk);
            if (uart_rd === 1'b1) rd_pulses++;
            check_output("cyc_uart_rd", {31'b0, uart_rd}, {31'b0, m_uart_rd});
            check_output("cyc_irq", {31'b0, irq}, {31'b0, m_irq});
            check_output("cyc_rdata", sys_rdata, m_rdata);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic bus_idle();
        sys_rd = 1'b0; sys_data_sel = 1'b0; sys_stat_sel = 1'b0;
        sys_we = 4'h0; sys_wdata = '0;
    endtask

    task automatic apply_stimulus(input logic rd, input logic dsel, input logic ssel,
                                  input logic [3:0] we, input logic [31:0] wdata);
        sys_rd = rd; sys_data_sel = dsel; sys_stat_sel = ssel; sys_we = we; sys_wdata = wdata;
        @(negedge input_clk);
        #1;
        bus_idle();
    endtask

    task automatic read_data(input logic [31:0] expected);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
        check_output("data_read", sys_rdata, expected);
    endtask

    task automatic read_stat(input logic [31:0] expected);
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'h0, 32'h0);
        check_output("status_read", sys_rdata, expected);
    endtask

    task automatic write_ctrl(input logic [31:0] value);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4'h1, value);
    endtask

    // Emulates the buart dropping valid on the edge after it sees rd.
    task automatic finish_handshake();
        @(posedge input_clk);
        #1;
        uart_valid = 1'b0;
        @(negedge input_clk);
        #1;
    endtask

    task automatic wait_ack(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge input_clk);
            if (uart_rd === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL %s: no uart_rd within 20 cycles, expected an ack", name);
        end
        finish_handshake();
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_valid = 1'b1;
        uart_data  = b;
        wait_ack("send_ack");
    endtask

    initial begin
        uart_valid = 1'b0;
        uart_data  = '0;
        bus_idle();
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge input_clk);
        #1 reset = 1'b0;
        check_output("reset_uart_rd", {31'b0, uart_rd}, 32'h0);
        check_output("reset_irq", {31'b0, irq}, 32'h0);
        check_output("reset_rdata", sys_rdata, 32'h0);
        read_stat(32'h0000_0000);

        // Basic capture and drain.
        rd_pulses = 0;
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
        check_output("one_pulse_per_byte", rd_pulses, 32'd3);
        read_stat(32'h0003_0001);
        read_data(32'h141); read_data(32'h142); read_data(32'h143);
        read_data(32'h000);

        // Fill, overflow, drain across the pointer wrap.
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_byte(8'hFF);
        read_stat(32'h0010_0007);
        for (int i = 0; i < 16; i++) read_data(32'h100 + 32'(i));
        read_stat(32'h0000_0004);
        write_ctrl(32'h1);
        read_stat(32'h0000_0000);

        // Interrupt threshold.
        write_ctrl(32'h4);
        send_byte(8'h10); send_byte(8'h11); send_byte(8'h12);
        check_output("irq_below_thresh", {31'b0, irq}, 32'h0);
        send_byte(8'h13);
        check_output("irq_at_thresh", {31'b0, irq}, 32'h1);
        read_data(32'h110);
        check_output("irq_after_pop", {31'b0, irq}, 32'h0);
        write_ctrl(32'h0);
        for (int i = 0; i < 13; i++) send_byte(8'h20 + 8'(i));
        send_byte(8'h2D);
        check_output("irq_masked_overrun", {31'b0, irq}, 32'h0);
        read_stat(32'h0010_0007);
        write_ctrl(32'h1);

        // Push and pop together while full.
        uart_valid = 1'b1;
        uart_data  = 8'h99;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
        check_output("full_pushpop_head", sys_rdata, 32'h111);
        finish_handshake();
        read_stat(32'h0010_0003);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp_v;
            if (i == 0) exp_v = 32'h112;
            else if (i == 1) exp_v = 32'h113;
            else if (i == 15) exp_v = 32'h199;
            else exp_v = 32'h120 + 32'(i - 2);
            read_data(exp_v);
        end

        // Flush concurrent with a push.
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
        read_stat(32'h0005_0001);
        uart_valid = 1'b1;
        uart_data  = 8'h55;
        write_ctrl(32'h2);
        finish_handshake();
        read_stat(32'h0000_0000);
        read_data(32'h000);

        // Flush concurrent with a pop returns the head.
        send_byte(8'h70); send_byte(8'h71);
        apply_stimulus(1'b1, 1'b1, 1'b1, 4'h1, 32'h2);
        check_output("flush_pop_head", sys_rdata, 32'h170);
        read_stat(32'h0000_0000);

        // Reset while acknowledging, with the buart still holding a byte.
        for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i));
        uart_valid = 1'b1;
        uart_data  = 8'h66;
        @(posedge input_clk);
        #1;
        check_output("ack_before_reset", {31'b0, uart_rd}, 32'h1);
        reset = 1'b1;
        #1;
        check_output("midreset_uart_rd", {31'b0, uart_rd}, 32'h0);
        check_output("midreset_irq", {31'b0, irq}, 32'h0);
        check_output("midreset_rdata", sys_rdata, 32'h0);
        @(negedge input_clk);
        @(negedge input_clk);
        #1;
        rd_pulses = 0;
        reset = 1'b0;
        wait_ack("post_reset_ack");
        repeat (3) @(negedge input_clk);
        #1;
        check_output("post_reset_pulses", rd_pulses, 32'd1);
        read_stat(32'h0001_0001);
        read_data(32'h166);

        repeat (2) @(negedge input_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
